fsm_out_wrmem: RTL
==================

FSM_OUT_WRMEM -- requirements
Module: fsm_out_wrmem

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the accelerator output data and memory write data width.
REQ-002 The module SHALL have parameter ADDR_W, default 10, giving the memory address width.
REQ-003 The module SHALL have parameter CNT_W, default 10, giving the burst and total word counter width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (rst=0 resets).
REQ-006 The module SHALL have port start, input, 1 bit: request to store; a low level clears the transfer.
REQ-007 The module SHALL have port selected, input, 1 bit: this output port is granted by the port selector.
REQ-008 The module SHALL have port base_addr, input, ADDR_W bits: first memory address of the transfer.
REQ-009 The module SHALL have port burst_len, input, CNT_W bits: words per burst.
REQ-010 The module SHALL have port total_len, input, CNT_W bits: words per transfer.
REQ-011 The module SHALL have port OUT_send, input, 1 bit: accelerator output data valid.
REQ-012 The module SHALL have port OUT_data, input, DATA_W bits: accelerator output data.
REQ-013 The module SHALL have port IN_rdy, output, 1 bit: ready returned to the accelerator output port.
REQ-014 The module SHALL have port portEn, output, 1 bit: enable the port selector.
REQ-015 The module SHALL have port free, output, 1 bit: release the port selector.
REQ-016 The module SHALL have port mem_en, output, 1 bit: memory enable.
REQ-017 The module SHALL have port mem_we, output, 1 bit: memory write strobe.
REQ-018 The module SHALL have port mem_addr, output, ADDR_W bits: memory write address.
REQ-019 The module SHALL have port mem_wdata, output, DATA_W bits: memory write data.
REQ-020 The module SHALL have port endrecv, output, 1 bit: level flag, all total_len words stored.

Function
REQ-021 The FSM SHALL use states IDLE, ARM, RECV and FREE, encoded on 2 bits.
REQ-022 IDLE SHALL go to ARM when !endrecv && start && selected; otherwise it stays in IDLE.
REQ-023 On the IDLE->ARM edge the burst counter SHALL load 0.
REQ-024 In IDLE, portEn SHALL equal !selected (Mealy).
REQ-025 In IDLE with start=0, the total counter SHALL clear to 0, the address pointer SHALL load base_addr, and endrecv SHALL fall within the same clock edge.
REQ-026 ARM SHALL last one cycle with mem_en=1 and IN_rdy=0.
REQ-027 ARM SHALL go to FREE if burst_len==0; otherwise it goes to RECV.
REQ-028 RECV SHALL drive IN_rdy=1 and mem_en=1 (Moore).
REQ-029 A handshake SHALL occur on any cycle with IN_rdy && OUT_send; each handshake increments the burst counter, total counter and address pointer by 1.
REQ-030 RECV SHALL go to FREE on a handshake where burst_cnt+1==burst_len or total_cnt+1==total_len; otherwise it stays in RECV.
REQ-031 RECV without OUT_send SHALL hold state, and no count or write occurs.
REQ-032 FREE SHALL last one cycle with free=1, IN_rdy=0, mem_en=1, then go to IDLE.
REQ-033 mem_we, mem_addr and mem_wdata SHALL be registered: the cycle after a handshake, mem_we=1, mem_addr=pointer before increment and mem_wdata=OUT_data; otherwise mem_we=0 and addr/data hold.
REQ-034 The final word's write SHALL land during FREE; mem_en SHALL be 1 on that cycle.
REQ-035 The address pointer SHALL wrap modulo 2^ADDR_W, and counters SHALL compare at CNT_W bits.
REQ-036 endrecv SHALL set on the clock edge where the total counter reaches total_len; total_len==0 SHALL give endrecv=1 after the start=0 clear, so IDLE never leaves.
REQ-037 When the last burst word and the last total word coincide, the FSM SHALL enter FREE once and endrecv SHALL be 1 in that same FREE cycle.
REQ-038 A start drop mid-burst SHALL NOT abort the burst; the clear applies only in IDLE.
REQ-039 burst_len, total_len and base_addr SHALL be sampled live and are required stable from IDLE->ARM until endrecv.

Reset
REQ-040 rst=0 SHALL asynchronously force state IDLE, all counters and the pointer to 0, and IN_rdy, free, mem_en, mem_we, endrecv, mem_addr and mem_wdata to 0; portEn then equals !selected.
REQ-041 A reset asserted mid-RECV SHALL abort the transfer with no further write, and after release the FSM restarts from IDLE.
REQ-042 Reset release SHALL be synchronous to clk.

Verification
REQ-043 Basic transfer SHALL be covered: base_addr=0x10, burst_len=4, total_len=4, start=1, selected=1, OUT_send=1 constant, data 0xA0..0xA3 -> writes 0x10..0x13; IDLE-ARM-RECVx4-FREE; endrecv=1 after FREE.
REQ-044 Multi-burst SHALL be covered: burst_len=3, total_len=7 -> bursts of 3, 3 and 1 with FREE after each; 7 writes at consecutive addresses; no re-entry once endrecv=1.
REQ-045 Stall SHALL be covered: OUT_send toggled 1,0,0,1 in RECV -> exactly 2 writes, counters unchanged on idle cycles, IN_rdy held at 1.
REQ-046 Boundary cases SHALL be covered: burst_len=0 -> ARM->FREE with no write; total_len=0 -> endrecv=1 and no ARM; base_addr=2^ADDR_W-1 with 2 words -> addresses wrap 0x3FF then 0x000.
REQ-047 Reset SHALL be covered: rst=0 after 2 of 4 handshakes -> immediate outputs 0 and no third write; start=0 then 1 -> a fresh transfer from base_addr.

Source files
------------

// File: rtl/fsm_out_wrmem_if.sv
// Accelerator output stream plus memory write port for the output-to-memory mover.
// The controller takes the master side.
interface fsm_out_wrmem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
);
  logic              OUT_send;
  logic [DATA_W-1:0] OUT_data;
  logic              IN_rdy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    input  OUT_send, OUT_data,
    output IN_rdy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output OUT_send, OUT_data,
    input  IN_rdy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fsm_out_wrmem.sv
// Moves accelerator output words into consecutive memory addresses in bursts,
// releasing the port selector after each burst and flagging the end of the transfer.
module fsm_out_wrmem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              selected,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [CNT_W-1:0]  total_len,
  output logic              portEn,
  output logic              free,
  output logic              endrecv,
  fsm_out_wrmem_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RECV = 2'd2,
    FREE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]  total_cnt_q, total_cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              endrecv_q, endrecv_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              in_rdy;
  logic              mem_en;
  logic              handshake;
  logic [CNT_W-1:0]  burst_inc;
  logic [CNT_W-1:0]  total_inc;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    total_cnt_d = total_cnt_q;
    ptr_d       = ptr_q;
    endrecv_d   = endrecv_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    portEn      = 1'b0;
    free        = 1'b0;
    mem_en      = 1'b0;

    in_rdy    = (state_q == RECV);
    handshake = in_rdy && bus.OUT_send;
    burst_inc = burst_cnt_q + CNT_W'(1);
    total_inc = total_cnt_q + CNT_W'(1);

    // The write is registered one cycle behind the handshake, using the pre-increment pointer.
    if (handshake) begin
      burst_cnt_d = burst_inc;
      total_cnt_d = total_inc;
      ptr_d       = ptr_q + ADDR_W'(1);
      mem_we_d    = 1'b1;
      mem_addr_d  = ptr_q;
      mem_wdata_d = bus.OUT_data;
      if (total_inc == total_len) begin
        endrecv_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        portEn = !selected;
        // Dropping start rearms the transfer; an empty transfer is finished immediately.
        if (!start) begin
          total_cnt_d = '0;
          ptr_d       = base_addr;
          endrecv_d   = (total_len == '0);
        end
        if (!endrecv_q && start && selected) begin
          state_d     = ARM;
          burst_cnt_d = '0;
        end
      end
      ARM: begin
        mem_en = 1'b1;
        if (burst_len == '0) begin
          state_d = FREE;
        end else begin
          state_d = RECV;
        end
      end
      RECV: begin
        mem_en = 1'b1;
        if (handshake && (burst_inc == burst_len || total_inc == total_len)) begin
          state_d = FREE;
        end
      end
      FREE: begin
        mem_en  = 1'b1;
        free    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      total_cnt_q <= '0;
      ptr_q       <= '0;
      endrecv_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      total_cnt_q <= total_cnt_d;
      ptr_q       <= ptr_d;
      endrecv_q   <= endrecv_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign endrecv       = endrecv_q;
  assign bus.IN_rdy    = in_rdy;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
